// File: rtl/glcm_engine.sv
// ------------------------------------------------------------------------------------------
// glcm_engine: AXI-fed 32x32 grey-level co-occurrence matrix engine, rev 1.0.
// Build macro GLCM_SAT_EN: matrix counts saturate at 255 instead of wrapping.
// ------------------------------------------------------------------------------------------
`default_nettype none
module glcm_engine #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr_M,
  input  logic [ADDR_WIDTH-1:0] in_addr_G,
  input  logic [1:0]            in_dir,
  input  logic [3:0]            in_dis,
  output logic                  out_valid,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [3:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf,
  output logic [ID_WIDTH-1:0]   awid_m_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
  output logic [2:0]            awsize_m_inf,
  output logic [1:0]            awburst_m_inf,
  output logic [3:0]            awlen_m_inf,
  output logic                  awvalid_m_inf,
  input  logic                  awready_m_inf,
  output logic [DATA_WIDTH-1:0] wdata_m_inf,
  output logic                  wlast_m_inf,
  output logic                  wvalid_m_inf,
  input  logic                  wready_m_inf,
  input  logic [ID_WIDTH-1:0]   bid_m_inf,
  input  logic [1:0]            bresp_m_inf,
  input  logic                  bvalid_m_inf,
  output logic                  bready_m_inf
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WR_ADDR = 3'd4;
  localparam logic [2:0] S_WR_DATA = 3'd5;
  localparam logic [2:0] S_WR_RESP = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]            r_state;
  logic [3:0]            r_burst;
  logic [3:0]            r_beat;
  logic [9:0]            r_pos;
  logic [ADDR_WIDTH-1:0] r_base_m;
  logic [ADDR_WIDTH-1:0] r_base_g;
  logic [3:0]            r_dr;
  logic [3:0]            r_dc;

  logic [4:0] r_img  [0:1023];
  logic [7:0] r_glcm [0:1023];

  logic [3:0]  w_dist;
  logic [3:0]  w_dr;
  logic [3:0]  w_dc;
  logic [5:0]  w_nrow;
  logic [5:0]  w_ncol;
  logic        w_pair_ok;
  logic [4:0]  w_pi;
  logic [4:0]  w_pj;
  logic [9:0]  w_gidx;
  logic [7:0]  w_gcur;
  logic [7:0]  w_gnext;
  logic [7:0]  w_widx;
  logic [31:0] w_word;
  logic        w_accept;
  logic        w_unused;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_dist   = (in_dis == 4'd0) ? 4'd1 : in_dis;

  always_comb begin
    w_dr = 4'd0;
    w_dc = w_dist;
    case (in_dir)
      2'b10:   begin w_dr = w_dist; w_dc = 4'd0;   end
      2'b11:   begin w_dr = w_dist; w_dc = w_dist; end
      default: begin w_dr = 4'd0;   w_dc = w_dist; end
    endcase
  end

  // A carry out of either 6-bit sum means the neighbour falls off the image.
  assign w_nrow    = {1'b0, r_pos[9:5]} + {2'b00, r_dr};
  assign w_ncol    = {1'b0, r_pos[4:0]} + {2'b00, r_dc};
  assign w_pair_ok = !w_nrow[5] && !w_ncol[5];
  assign w_pi      = r_img[r_pos];
  assign w_pj      = r_img[{w_nrow[4:0], w_ncol[4:0]}];
  assign w_gidx    = {w_pi, w_pj};
  assign w_gcur    = r_glcm[w_gidx];
`ifdef GLCM_SAT_EN
  assign w_gnext   = (w_gcur == 8'hFF) ? w_gcur : w_gcur + 8'd1;
`else
  assign w_gnext   = w_gcur + 8'd1;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_burst  <= 4'd0;
      r_beat   <= 4'd0;
      r_pos    <= 10'd0;
      r_base_m <= '0;
      r_base_g <= '0;
      r_dr     <= 4'd0;
      r_dc     <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_base_m <= in_addr_M;
          r_base_g <= in_addr_G;
          r_dr     <= w_dr;
          r_dc     <= w_dc;
          r_burst  <= 4'd0;
          r_beat   <= 4'd0;
          r_pos    <= 10'd0;
          r_state  <= S_RD_ADDR;
        end
        S_RD_ADDR: if (arready_m_inf) begin
          r_beat  <= 4'd0;
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: if (rvalid_m_inf) begin
          r_beat <= r_beat + 4'd1;
          if (rlast_m_inf) begin
            r_burst <= r_burst + 4'd1;
            r_state <= (r_burst == 4'd15) ? S_COMPUTE : S_RD_ADDR;
          end
        end
        S_COMPUTE: begin
          r_pos <= r_pos + 10'd1;
          if (r_pos == 10'd1023) r_state <= S_WR_ADDR;
        end
        S_WR_ADDR: if (awready_m_inf) begin
          r_beat  <= 4'd0;
          r_state <= S_WR_DATA;
        end
        S_WR_DATA: if (wready_m_inf) begin
          r_beat <= r_beat + 4'd1;
          if (r_beat == 4'd15) r_state <= S_WR_RESP;
        end
        S_WR_RESP: if (bvalid_m_inf) begin
          r_burst <= r_burst + 4'd1;
          r_state <= (r_burst == 4'd15) ? S_DONE : S_WR_ADDR;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 1024; i++) r_glcm[i] <= 8'd0;
    end else if ((r_state == S_COMPUTE) && w_pair_ok) begin
      r_glcm[w_gidx] <= w_gnext;
    end
    if ((r_state == S_RD_DATA) && rvalid_m_inf) begin
      for (int b = 0; b < 4; b++) r_img[{r_burst, r_beat, 2'(b)}] <= rdata_m_inf[8*b +: 5];
    end
  end

  assign w_widx = {r_burst, r_beat};
  assign w_word = {r_glcm[{w_widx, 2'd3}], r_glcm[{w_widx, 2'd2}],
                   r_glcm[{w_widx, 2'd1}], r_glcm[{w_widx, 2'd0}]};

  assign arvalid_m_inf = (r_state == S_RD_ADDR);
  assign arid_m_inf    = '0;
  assign araddr_m_inf  = arvalid_m_inf ? r_base_m + ADDR_WIDTH'({r_burst, 6'd0}) : '0;
  assign arlen_m_inf   = arvalid_m_inf ? 4'd15  : 4'd0;
  assign arsize_m_inf  = arvalid_m_inf ? 3'b010 : 3'b000;
  assign arburst_m_inf = arvalid_m_inf ? 2'b01  : 2'b00;
  assign rready_m_inf  = (r_state == S_RD_DATA);

  assign awvalid_m_inf = (r_state == S_WR_ADDR);
  assign awid_m_inf    = '0;
  assign awaddr_m_inf  = awvalid_m_inf ? r_base_g + ADDR_WIDTH'({r_burst, 6'd0}) : '0;
  assign awlen_m_inf   = awvalid_m_inf ? 4'd15  : 4'd0;
  assign awsize_m_inf  = awvalid_m_inf ? 3'b010 : 3'b000;
  assign awburst_m_inf = awvalid_m_inf ? 2'b01  : 2'b00;
  assign wvalid_m_inf  = (r_state == S_WR_DATA);
  assign wlast_m_inf   = wvalid_m_inf && (r_beat == 4'd15);
  assign wdata_m_inf   = wvalid_m_inf ? DATA_WIDTH'(w_word) : '0;
  assign bready_m_inf  = (r_state == S_WR_RESP);

  assign out_valid = (r_state == S_DONE);

  assign w_unused = ^{rid_m_inf, rresp_m_inf, bid_m_inf, bresp_m_inf, rdata_m_inf};

endmodule
`default_nettype wire

// File: tb/tb_glcm_engine.sv
// ------------------------------------------------------------------------------------------
// tb_glcm_engine: directed bench for glcm_engine with a byte-memory AXI slave, rev 1.0.
// ------------------------------------------------------------------------------------------
`default_nettype none
module tb_glcm_engine;

  localparam int IDW    = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int OUTW   = 129;
  localparam int C_MOFF = 'h1000;
  localparam int C_GOFF = 'h1400;
`ifdef GLCM_SAT_EN
  localparam int C_ZERO_G00 = 255;
`else
  localparam int C_ZERO_G00 = 224;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [AW-1:0]  in_addr_M, in_addr_G;
  logic [1:0]     in_dir;
  logic [3:0]     in_dis;
  logic           out_valid;
  logic [IDW-1:0] arid, rid, awid, bid;
  logic [AW-1:0]  araddr, awaddr;
  logic [3:0]     arlen, awlen;
  logic [2:0]     arsize, awsize;
  logic [1:0]     arburst, awburst, rresp, bresp;
  logic           arvalid, arready, rlast, rvalid, rready;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]  rdata, wdata;
  logic [OUTW-1:0] all_outs;

  always #5 clk = ~clk;

  glcm_engine #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_addr_M(in_addr_M),
    .in_addr_G(in_addr_G), .in_dir(in_dir), .in_dis(in_dis), .out_valid(out_valid),
    .arid_m_inf(arid), .araddr_m_inf(araddr), .arlen_m_inf(arlen), .arsize_m_inf(arsize),
    .arburst_m_inf(arburst), .arvalid_m_inf(arvalid), .arready_m_inf(arready),
    .rid_m_inf(rid), .rdata_m_inf(rdata), .rresp_m_inf(rresp), .rlast_m_inf(rlast),
    .rvalid_m_inf(rvalid), .rready_m_inf(rready),
    .awid_m_inf(awid), .awaddr_m_inf(awaddr), .awsize_m_inf(awsize),
    .awburst_m_inf(awburst), .awlen_m_inf(awlen), .awvalid_m_inf(awvalid),
    .awready_m_inf(awready), .wdata_m_inf(wdata), .wlast_m_inf(wlast),
    .wvalid_m_inf(wvalid), .wready_m_inf(wready), .bid_m_inf(bid), .bresp_m_inf(bresp),
    .bvalid_m_inf(bvalid), .bready_m_inf(bready)
  );

  assign all_outs = {out_valid, arid, araddr, arlen, arsize, arburst, arvalid, rready,
                     awid, awaddr, awsize, awburst, awlen, awvalid, wdata, wlast, wvalid, bready};

  logic [7:0] mem   [0:8191];
  logic [7:0] exp_g [0:1023];
  int checks = 0, failures = 0;
  int ar_cnt, aw_cnt, ov_cnt, fmt_err, wl_err, first_bad;
  bit rand_dly = 1'b0;

  function automatic int pick();
    return rand_dly ? int'($urandom_range(0, 7)) : 0;
  endfunction

  function automatic int mat_bad();
    int n = 0;
    first_bad = 0;
    for (int i = 0; i < 1024; i++)
      if (mem[C_GOFF + i] !== exp_g[i]) begin
        if (n == 0) first_bad = i;
        n++;
      end
    return n;
  endfunction

  always @(negedge clk) if (out_valid === 1'b1) ov_cnt++;

  initial begin : rd_slave
    int dly, a;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = 2'b10;
    forever begin
      @(negedge clk);
      if (!rst_n && arvalid) begin
        dly = pick();
        while (dly > 0) begin @(negedge clk); dly--; end
        if (arlen !== 4'd15 || arsize !== 3'b010 || arburst !== 2'b01 || arid !== '0) fmt_err++;
        a = int'(araddr[12:0]);
        ar_cnt++;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 16; b++) begin
          dly = pick();
          while (dly > 0) begin @(negedge clk); dly--; end
          rvalid = 1'b1;
          rlast  = (b == 15);
          rdata  = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
          while (!rready) @(negedge clk);
          @(negedge clk);
          rvalid = 1'b0; rlast = 1'b0;
          a += 4;
        end
      end
    end
  end

  initial begin : wr_slave
    int dly, a;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = 2'b10;
    forever begin
      @(negedge clk);
      if (!rst_n && awvalid) begin
        dly = pick();
        while (dly > 0 && !rst_n) begin @(negedge clk); dly--; end
        if (awlen !== 4'd15 || awsize !== 3'b010 || awburst !== 2'b01 || awid !== '0) fmt_err++;
        a = int'(awaddr[12:0]);
        aw_cnt++;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        for (int b = 0; b < 16 && !rst_n; b++) begin
          dly = pick();
          while (dly > 0 && !rst_n) begin @(negedge clk); dly--; end
          wready = 1'b1;
          while (!wvalid && !rst_n) @(negedge clk);
          if (!rst_n) begin
            if (wlast !== (b == 15)) wl_err++;
            for (int k = 0; k < 4; k++) mem[a + 4*b + k] = wdata[8*k +: 8];
          end
          @(negedge clk);
          wready = 1'b0;
        end
        if (!rst_n) begin
          dly = pick();
          while (dly > 0 && !rst_n) begin @(negedge clk); dly--; end
          bvalid = 1'b1;
          while (!bready && !rst_n) @(negedge clk);
          @(negedge clk);
          bvalid = 1'b0;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      end
    end
  end

  // mode 0: all zero, 1: pixel=c with junk in bits 7:5, 2: pixel=r, 3: pixel=(r+c)&31
  task automatic prep(input int mode);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        case (mode)
          1:       mem[C_MOFF + 32*r + c] = 8'hA0 | 8'(c);
          2:       mem[C_MOFF + 32*r + c] = 8'(r);
          3:       mem[C_MOFF + 32*r + c] = 8'((r + c) & 31);
          default: mem[C_MOFF + 32*r + c] = 8'h00;
        endcase
    for (int i = 0; i < 1024; i++) begin
      mem[C_GOFF + i] = 8'hA5;
      exp_g[i] = 8'h00;
    end
    ar_cnt = 0; aw_cnt = 0; ov_cnt = 0; fmt_err = 0; wl_err = 0;
  endtask

  task automatic run_cmd(input logic [1:0] dir, input logic [3:0] dis, output bit done);
    @(negedge clk);
    in_valid = 1'b1; in_addr_M = AW'(C_MOFF); in_addr_G = AW'(C_GOFF);
    in_dir = dir; in_dis = dis;
    @(negedge clk);
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) done = 1'b1;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b1; in_addr_M = '1; in_addr_G = '1; in_dir = 2'b11; in_dis = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got %h want 0", all_outs);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all_zero();
    bit done; int nbad;
    prep(0);
    exp_g[0] = 8'(C_ZERO_G00);
    run_cmd(2'b01, 4'd1, done);
    checks++; if (!done) begin failures++; $display("FAIL zero_done: got 0 want 1"); end
    checks++;
    if (mem[C_GOFF] !== 8'(C_ZERO_G00)) begin
      failures++; $display("FAIL zero_g00: got %0d want %0d", mem[C_GOFF], C_ZERO_G00);
    end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL zero_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL zero_pulses: got %0d want 1", ov_cnt); end
    checks++; if (fmt_err !== 0) begin failures++; $display("FAIL burst_fields: got %0d errors want 0", fmt_err); end
    checks++; if (wl_err !== 0) begin failures++; $display("FAIL wlast: got %0d errors want 0", wl_err); end
  endtask

  task automatic test_row_ramp();
    bit done; int nbad;
    prep(1);
    for (int c = 0; c < 31; c++) exp_g[32*c + c + 1] = 8'd32;
    run_cmd(2'b01, 4'd1, done);
    checks++; if (!done) begin failures++; $display("FAIL ramp_done: got 0 want 1"); end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL ramp_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
    checks++; if (ar_cnt !== 16) begin failures++; $display("FAIL ramp_ar: got %0d want 16", ar_cnt); end
    checks++; if (aw_cnt !== 16) begin failures++; $display("FAIL ramp_aw: got %0d want 16", aw_cnt); end
  endtask

  task automatic test_col_dist2();
    bit done; int nbad;
    prep(2);
    for (int r = 0; r < 30; r++) exp_g[32*r + r + 2] = 8'd32;
    run_cmd(2'b10, 4'd2, done);
    checks++; if (!done) begin failures++; $display("FAIL col_done: got 0 want 1"); end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL col_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
  endtask

  task automatic test_diag();
    bit done; int on_sum, off_bad;
    prep(3);
    run_cmd(2'b11, 4'd15, done);
    checks++; if (!done) begin failures++; $display("FAIL diag_done: got 0 want 1"); end
    on_sum = 0; off_bad = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        if (j == ((i + 30) & 31)) on_sum += int'(mem[C_GOFF + 32*i + j]);
        else if (mem[C_GOFF + 32*i + j] !== 8'd0) off_bad++;
    checks++; if (on_sum !== 289) begin failures++; $display("FAIL diag_total: got %0d want 289", on_sum); end
    checks++; if (off_bad !== 0) begin failures++; $display("FAIL diag_offpattern: got %0d nonzero want 0", off_bad); end
    checks++; if (ar_cnt !== 16) begin failures++; $display("FAIL diag_ar: got %0d want 16", ar_cnt); end
    checks++; if (aw_cnt !== 16) begin failures++; $display("FAIL diag_aw: got %0d want 16", aw_cnt); end
  endtask

  // dir=00/dis=0 must behave as dir=01/dis=1; in_valid pulses while busy are ignored
  task automatic test_defaults_busy();
    bit done; int nbad;
    prep(1);
    for (int c = 0; c < 31; c++) exp_g[32*c + c + 1] = 8'd32;
    fork
      run_cmd(2'b00, 4'd0, done);
      begin
        repeat (100) @(negedge clk);
        in_valid = 1'b1; in_addr_G = 32'h0000_0800; in_dir = 2'b10; in_dis = 4'd5;
        @(negedge clk); in_valid = 1'b0;
        repeat (500) @(negedge clk);
        in_valid = 1'b1; in_addr_M = 32'h0000_0000;
        @(negedge clk); in_valid = 1'b0;
      end
    join
    checks++; if (!done) begin failures++; $display("FAIL dflt_done: got 0 want 1"); end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL dflt_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL dflt_pulses: got %0d want 1", ov_cnt); end
  endtask

  task automatic test_random_delay();
    bit done; int nbad;
    prep(1);
    for (int c = 0; c < 31; c++) exp_g[32*c + c + 1] = 8'd32;
    rand_dly = 1'b1;
    run_cmd(2'b01, 4'd1, done);
    rand_dly = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL rand_done: got 0 want 1"); end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL rand_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL rand_pulses: got %0d want 1", ov_cnt); end
    checks++; if (wl_err !== 0) begin failures++; $display("FAIL rand_wlast: got %0d errors want 0", wl_err); end
  endtask

  task automatic test_reset_abort();
    bit done, seen; int nbad;
    prep(1);
    @(negedge clk);
    in_valid = 1'b1; in_addr_M = AW'(C_MOFF); in_addr_G = AW'(C_GOFF); in_dir = 2'b01; in_dis = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (wvalid === 1'b1 && aw_cnt >= 3) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_reach_wdata: got 0 want 1"); end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (all_outs !== '0) begin
        failures++;
        $display("FAIL abort_outputs: got %h want 0", all_outs);
      end
    end
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    prep(2);
    for (int r = 0; r < 30; r++) exp_g[32*r + r + 2] = 8'd32;
    run_cmd(2'b10, 4'd2, done);
    checks++; if (!done) begin failures++; $display("FAIL abort_next_done: got 0 want 1"); end
    nbad = mat_bad();
    checks++;
    if (nbad !== 0) begin
      failures++;
      $display("FAIL abort_next_matrix: bad=%0d idx=%0d got %0d want %0d", nbad, first_bad,
               mem[C_GOFF + first_bad], exp_g[first_bad]);
    end
    checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL abort_next_pulses: got %0d want 1", ov_cnt); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_zero();
    test_row_ramp();
    test_col_dist2();
    test_diag();
    test_defaults_busy();
    test_random_delay();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
